// File: rtl/sample_frame_loader_if.sv
// Frame release handshake between the byte loader and the per-channel detectors.
// The loader drives data/valid; the detector side returns ready.
interface sample_frame_loader_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 16
);
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_data;
    logic                               frame_valid;
    logic                               frame_ready;

    modport master (output frame_data, output frame_valid, input frame_ready);
    modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/sample_frame_loader.sv
// Byte-serial frame receiver for the TT wrapper: loads MSB-first bytes, releases a
// frame on a read trigger, and returns the latched detector event of a selected channel.
module sample_frame_loader #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    wr_strobe,
    input  logic                    rd_trigger,
    input  logic [7:0]              byte_in,
    input  logic [1:0]              ch_sel,
    input  logic                    clr_status,
    sample_frame_loader_if.master   frame,
    input  logic                    event_valid,
    input  logic [NUM_CHANNELS-1:0] event_vec,
    output logic                    evt_out,
    output logic [3:0]              status
);
    localparam int W     = NUM_CHANNELS * DATA_WIDTH;
    localparam int BYTES = W / 8;
    localparam int CW    = $clog2(BYTES + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(BYTES);

    logic          wr_q, rd_q;
    logic          wr_pulse, rd_pulse;
    logic [W-1:0]  shift_reg, frame_data_r;
    logic          frame_valid_r;
    logic [CW-1:0] byte_cnt, cnt_eff;
    logic          frame_full;
    logic          release_ok, resync, drop_set;
    logic          wr_accept, overrun_set;
    logic          overrun, short_frame, drop;
    logic [3:0]    event_reg;

    always_comb begin
        wr_pulse    = ena & wr_strobe & ~wr_q;
        rd_pulse    = ena & rd_trigger & ~rd_q;
        frame_full  = (byte_cnt == FULL_CNT);
        release_ok  = rd_pulse & frame_full & ~frame_valid_r;
        resync      = rd_pulse & ~frame_full;
        drop_set    = rd_pulse & frame_full & frame_valid_r;
        // Release is resolved first, so a same-cycle write sees the post-release count.
        cnt_eff     = (release_ok | resync) ? '0 : byte_cnt;
        wr_accept   = wr_pulse & (cnt_eff != FULL_CNT);
        overrun_set = wr_pulse & (cnt_eff == FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q          <= 1'b0;
            rd_q          <= 1'b0;
            shift_reg     <= '0;
            byte_cnt      <= '0;
            frame_data_r  <= '0;
            frame_valid_r <= 1'b0;
            overrun       <= 1'b0;
            short_frame   <= 1'b0;
            drop          <= 1'b0;
            event_reg     <= '0;
            evt_out       <= 1'b0;
        end else if (ena) begin
            wr_q <= wr_strobe;
            rd_q <= rd_trigger;

            if (wr_accept) begin
                // Low W bits of the concatenation: works down to a single-byte frame.
                shift_reg <= W'({shift_reg, byte_in});
                byte_cnt  <= cnt_eff + 1'b1;
            end else begin
                byte_cnt  <= cnt_eff;
            end

            if (release_ok) begin
                frame_data_r  <= shift_reg;
                frame_valid_r <= 1'b1;
            end else if (frame_valid_r && frame.frame_ready) begin
                frame_valid_r <= 1'b0;
            end

            overrun     <= overrun_set | (overrun & ~clr_status);
            short_frame <= resync | (short_frame & ~clr_status);
            drop        <= drop_set | (drop & ~clr_status);

            if (event_valid) begin
                event_reg <= 4'(event_vec);
            end
            evt_out <= ({1'b0, ch_sel} < 3'(NUM_CHANNELS)) ? event_reg[ch_sel] : 1'b0;
        end
    end

    assign frame.frame_data  = frame_data_r;
    assign frame.frame_valid = frame_valid_r;
    assign status            = {drop, short_frame, overrun, frame_full};

endmodule

// File: tb/tb_sample_frame_loader.sv
// Directed bench for sample_frame_loader: byte loading, release rules, sticky
// status, frame handshake and channel event readback.
module tb_sample_frame_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       wr_strobe;
    logic       rd_trigger;
    logic [7:0] byte_in;
    logic [1:0] ch_sel;
    logic       clr_status;
    logic       event_valid;
    logic [3:0] event_vec;
    logic       evt_out;
    logic [3:0] status;

    int checks = 0;
    int errors = 0;

    sample_frame_loader_if #(.NUM_CHANNELS(4), .DATA_WIDTH(16)) fr ();

    sample_frame_loader #(.NUM_CHANNELS(4), .DATA_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .wr_strobe   (wr_strobe),
        .rd_trigger  (rd_trigger),
        .byte_in     (byte_in),
        .ch_sel      (ch_sel),
        .clr_status  (clr_status),
        .frame       (fr.master),
        .event_valid (event_valid),
        .event_vec   (event_vec),
        .evt_out     (evt_out),
        .status      (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        byte_in   = b;
        wr_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd();
        rd_trigger = 1'b1;
        @(negedge clk);
        rd_trigger = 1'b0;
        @(negedge clk);
    endtask

    task automatic load(input logic [63:0] f);
        for (int i = 0; i < 8; i++) wr(f[63-8*i -: 8]);
    endtask

    task automatic accept();
        fr.frame_ready = 1'b1;
        @(negedge clk);
        fr.frame_ready = 1'b0;
        check("accept_valid_drop", fr.frame_valid, 1'b0);
    endtask

    task automatic clr();
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; wr_strobe = 1'b0; rd_trigger = 1'b0;
        byte_in = '0; ch_sel = '0; clr_status = 1'b0; event_valid = 1'b0;
        event_vec = '0; fr.frame_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_valid", fr.frame_valid, 1'b0);
        check("rst_data", fr.frame_data, 64'h0);
        check("rst_status", status, 4'b0000);
        check("rst_evt", evt_out, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame
        load(64'h0004_0003_0002_0001);
        check("full_status", status, 4'b0001);
        rd();
        check("basic_valid", fr.frame_valid, 1'b1);
        check("basic_data", fr.frame_data, 64'h0004_0003_0002_0001);
        check("basic_status", status, 4'b0000);
        accept();

        // Held strobe counts once
        byte_in = 8'hAA; wr_strobe = 1'b1;
        repeat (4) @(negedge clk);
        wr_strobe = 1'b0;
        @(negedge clk);
        check("held_cnt", dut.byte_cnt, 1);
        for (int i = 1; i < 8; i++) wr(8'(8'h11 * i));
        rd();
        check("held_data", fr.frame_data, 64'hAA11_2233_4455_6677);
        check("held_status", status, 4'b0000);
        accept();

        // Overrun
        load(64'h0102_0304_0506_0708);
        wr(8'h55);
        check("ovr_status", status, 4'b0011);
        rd();
        check("ovr_data", fr.frame_data, 64'h0102_0304_0506_0708);
        check("ovr_sticky", status, 4'b0010);
        clr();
        check("ovr_clr", status, 4'b0000);
        accept();

        // Short frame resync
        wr(8'h01); wr(8'h02); wr(8'h03);
        rd();
        check("short_valid", fr.frame_valid, 1'b0);
        check("short_status", status, 4'b0100);
        check("short_cnt", dut.byte_cnt, 0);
        clr();
        load(64'h1011_1213_1415_1617);
        rd();
        check("short_valid2", fr.frame_valid, 1'b1);
        check("short_data2", fr.frame_data, 64'h1011_1213_1415_1617);
        accept();

        // Drop while previous frame pending
        load(64'hA0A1_A2A3_A4A5_A6A7);
        rd();
        load(64'hB0B1_B2B3_B4B5_B6B7);
        rd();
        check("drop_status", status, 4'b1001);
        check("drop_data", fr.frame_data, 64'hA0A1_A2A3_A4A5_A6A7);
        check("drop_valid", fr.frame_valid, 1'b1);
        accept();
        rd();
        check("drop_b_valid", fr.frame_valid, 1'b1);
        check("drop_b_data", fr.frame_data, 64'hB0B1_B2B3_B4B5_B6B7);
        check("drop_b_status", status, 4'b1000);
        clr();
        accept();

        // Simultaneous write and release
        load(64'hC0C1_C2C3_C4C5_C6C7);
        byte_in = 8'hEE; wr_strobe = 1'b1; rd_trigger = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0; rd_trigger = 1'b0;
        @(negedge clk);
        check("sim_valid", fr.frame_valid, 1'b1);
        check("sim_data", fr.frame_data, 64'hC0C1_C2C3_C4C5_C6C7);
        check("sim_cnt", dut.byte_cnt, 1);
        check("sim_status", status, 4'b0000);
        accept();
        for (int i = 1; i < 8; i++) wr(8'(8'hE0 + i));
        rd();
        check("sim_next_data", fr.frame_data, 64'hEEE1_E2E3_E4E5_E6E7);
        accept();

        // ena low freezes state
        ena = 1'b0;
        wr(8'h99);
        ena = 1'b1;
        @(negedge clk);
        check("ena_cnt", dut.byte_cnt, 0);

        // Events
        event_valid = 1'b1; event_vec = 4'b0101; ch_sel = 2'd0;
        @(negedge clk);
        event_valid = 1'b0; event_vec = 4'b0000;
        @(negedge clk);
        check("evt_ch0", evt_out, 1'b1);
        ch_sel = 2'd1;
        #1 check("evt_latency", evt_out, 1'b1);
        @(negedge clk);
        check("evt_ch1", evt_out, 1'b0);
        ch_sel = 2'd2;
        @(negedge clk);
        check("evt_ch2", evt_out, 1'b1);
        ch_sel = 2'd3;
        @(negedge clk);
        check("evt_ch3", evt_out, 1'b0);
        ch_sel = 2'd2;
        @(negedge clk);
        check("evt_ch2b", evt_out, 1'b1);
        wr(8'h42);
        rst_n = 1'b0;
        #1 check("evt_rst", evt_out, 1'b0);
        check("rst_mid_cnt", dut.byte_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check("evt_after_rst", evt_out, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
